// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : Immediate extension unit (zero/sign/high/branch-offset forms)
//               with a valid/ready input and a 2-entry output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic             mode_err
);

  localparam int c_EXT_W = OUT_W - IN_W;

  localparam logic [2:0] c_MODE_ZERO = 3'd0;
  localparam logic [2:0] c_MODE_SIGN = 3'd1;
  localparam logic [2:0] c_MODE_HIGH = 3'd2;
  localparam logic [2:0] c_MODE_SHL2 = 3'd3;

  // Each entry is {mode_err, value}.
  logic [OUT_W:0]   r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic             w_push;
  logic             w_pop;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_val;
  logic             w_err;
  logic [OUT_W:0]   w_head;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_sext = {{c_EXT_W{imm_in[IN_W-1]}}, imm_in};
    w_val  = '0;
    w_err  = 1'b0;
    case (mode)
      c_MODE_ZERO: w_val = {{c_EXT_W{1'b0}}, imm_in};
      c_MODE_SIGN: w_val = w_sext;
      c_MODE_HIGH: w_val = {imm_in, {c_EXT_W{1'b0}}};
      c_MODE_SHL2: w_val = w_sext << 2;
      default:     w_err = 1'b1;
    endcase
  end

  for (genvar i = 0; i < 2; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[i] <= '0;
      end else if (w_push && (r_wr_ptr == 1'(i))) begin
        r_mem[i] <= {w_err, w_val};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty the read pointer sits on the slot to be written next, so the
  // most recently stored entry is the other slot; showing it keeps the
  // outputs stable while idle.
  assign w_head   = (r_count == 2'd0) ? r_mem[~r_rd_ptr] : r_mem[r_rd_ptr];
  assign imm_out  = w_head[OUT_W-1:0];
  assign mode_err = w_head[OUT_W];

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Self-checking bench for imm_ext_pipe: queue-based reference
//               model, per-cycle compare, directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_in;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  logic             mode_err;

  int total = 0;
  int bad   = 0;

  // Reference FIFO contents, each {mode_err, value}.
  logic [OUT_W:0] q[$];

  imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_in    (imm_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .mode_err  (mode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension rules evaluated as integer arithmetic on the immediate's value.
  function automatic logic [OUT_W:0] ref_ext(input logic [IN_W-1:0] imm, input logic [2:0] m);
    longint u;
    longint s;
    logic [OUT_W-1:0] v;
    u = longint'(imm);
    s = imm[IN_W-1] ? u - (longint'(1) << IN_W) : u;
    case (m)
      3'd0:    v = OUT_W'(u);
      3'd1:    v = OUT_W'(s);
      3'd2:    v = OUT_W'(u * (longint'(1) << (OUT_W - IN_W)));
      3'd3:    v = OUT_W'(s * 4);
      default: return {1'b1, {OUT_W{1'b0}}};
    endcase
    return {1'b0, v};
  endfunction

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      logic do_push;
      logic do_pop;
      do_push = in_valid && (q.size() < 2);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ref_ext(imm_in, mode));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(q.size() != 2));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) check("head", 64'({mode_err, imm_out}), 64'(q[0]));
    end
  end

  task automatic step(input logic v, input logic [IN_W-1:0] imm, input logic [2:0] m, input logic ordy);
    in_valid  = v;
    imm_in    = imm;
    mode      = m;
    out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; imm_in = '0; mode = '0; out_ready = 1'b0;

    // Pin the reference model to hand-computed values.
    check("model_zero", 64'(ref_ext(16'h8001, 3'd0)), 64'(33'h0_0000_8001));
    check("model_sign", 64'(ref_ext(16'h8001, 3'd1)), 64'(33'h0_FFFF_8001));
    check("model_high", 64'(ref_ext(16'h8001, 3'd2)), 64'(33'h0_8001_0000));
    check("model_shl2", 64'(ref_ext(16'h8001, 3'd3)), 64'(33'h0_FFFE_0004));
    check("model_rsvd", 64'(ref_ext(16'hFFFF, 3'd6)), 64'(33'h1_0000_0000));

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_imm_out", 64'(imm_out), 64'd0);
    check("rst_mode_err", 64'(mode_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    step(1'b1, 16'h8001, 3'd0, 1'b1);
    check("zero_out", 64'({out_valid, mode_err, imm_out}), 64'({1'b1, 1'b0, 32'h0000_8001}));
    step(1'b1, 16'h8001, 3'd1, 1'b1);
    check("sign_out", 64'(imm_out), 64'h0000_0000_FFFF_8001);
    step(1'b1, 16'h8001, 3'd2, 1'b1);
    check("high_out", 64'(imm_out), 64'h0000_0000_8001_0000);
    step(1'b1, 16'h8001, 3'd3, 1'b1);
    check("shl2_out", 64'(imm_out), 64'h0000_0000_FFFE_0004);
    step(1'b0, 16'h0, 3'd0, 1'b1);

    // Backpressure: two accepted, third held by the producer.
    step(1'b1, 16'h0001, 3'd0, 1'b0);
    step(1'b1, 16'h0002, 3'd0, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_head", 64'(imm_out), 64'd1);
    in_valid = 1'b1; imm_in = 16'h0003; mode = 3'd0; out_ready = 1'b1;
    n = 0;
    forever begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 10) begin
        check("bp_accept_timeout", 64'(n), 64'd0);
        break;
      end
    end
    check("bp_third_head", 64'(imm_out), 64'd3);
    step(1'b0, 16'h0, 3'd0, 1'b1);

    step(1'b1, 16'hFFFF, 3'd5, 1'b1);
    check("rsvd_out", 64'({mode_err, imm_out}), 64'({1'b1, 32'h0}));
    step(1'b1, 16'hFFFF, 3'd1, 1'b1);
    check("after_rsvd", 64'({mode_err, imm_out}), 64'({1'b0, 32'hFFFF_FFFF}));
    step(1'b0, 16'h0, 3'd0, 1'b1);

    // Count held at 1 with simultaneous push and pop.
    step(1'b1, 16'h0100, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'h0200 + i), 3'(i % 4), 1'b1);
      check("steady_ready", 64'({in_ready, out_valid}), 64'd3);
    end
    step(1'b0, 16'h0, 3'd0, 1'b1);

    // Asynchronous reset between edges with two entries buffered.
    step(1'b1, 16'h1111, 3'd0, 1'b0);
    step(1'b1, 16'h2222, 3'd0, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", 64'({out_valid, in_ready}), 64'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 16'h4321, 3'd0, 1'b1);
    check("post_rst_push", 64'({out_valid, imm_out}), 64'({1'b1, 32'h0000_4321}));
    step(1'b0, 16'h0, 3'd0, 1'b1);
    check("post_rst_alone", 64'(out_valid), 64'd0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      imm_in    = IN_W'($urandom);
      mode      = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
